systolic_feeder: RTL and testbench

Job sequencer that drives the 3x3 systolic_array from whole matrices and collects its results. It accepts a 3x3 A and a 3x3 B matrix with a valid/ready handshake. It clears the array, generates the diagonally skewed a1..a3 / b1..b3 streams, waits for the array to drain, then captures c1..c9 into a result register with an output handshake. It sits between the AP command logic and systolic_array and replaces hand-skewed stimulus.

---
 rtl/systolic_pkg.sv | 23 ++
 rtl/systolic_skew_sel.sv | 25 ++
 rtl/systolic_feeder.sv | 209 ++++++++++++++++++++
 tb/tb_systolic_feeder.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array job feeder: array geometry,
// feed length, sequencer states and the row-major element index helper.
package systolic_pkg;

    localparam int DEF_DATA_SIZE = 32;
    localparam int ARR_N         = 3;
    localparam int FEED_CYCLES   = 2 * ARR_N - 1;
    localparam int ELEMS         = ARR_N * ARR_N;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        HOLD
    } state_t;

    // Word index of element [r][c] in a packed row-major matrix.
    function automatic int elem_idx(input int r, input int c);
        return r * ARR_N + c;
    endfunction

endpackage

// File: rtl/systolic_skew_sel.sv
// Picks one word of a skewed stream: lane LANE is delayed by LANE cycles,
// so element k of the row/column is presented when t == k + LANE.
module systolic_skew_sel
    import systolic_pkg::*;
#(
    parameter int DATA_SIZE = DEF_DATA_SIZE,
    parameter int CNT_W     = 3,
    parameter int LANE      = 0
) (
    input  logic [ARR_N*DATA_SIZE-1:0] vec,
    input  logic [CNT_W-1:0]           t,
    output logic [DATA_SIZE-1:0]       word
);

    // Zero outside the lane's three-cycle window, otherwise the matching element.
    always_comb begin
        word = '0;
        for (int k = 0; k < ARR_N; k++) begin
            if (t == CNT_W'(k + LANE)) begin
                word = vec[k*DATA_SIZE +: DATA_SIZE];
            end
        end
    end

endmodule

// File: rtl/systolic_feeder.sv
// Job sequencer for the 3x3 systolic array: accepts A/B matrices, clears the
// array, feeds diagonally skewed row/column streams, waits for the array to
// drain and holds the captured C matrix until the consumer takes it.
// Optional: define SYSTOLIC_FEEDER_PERF_EN for job_count / busy_cycles.
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int DATA_SIZE    = DEF_DATA_SIZE,
    parameter int DRAIN_CYCLES = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ELEMS*DATA_SIZE-1:0]   mat_a,
    input  logic [ELEMS*DATA_SIZE-1:0]   mat_b,
    output logic                         arr_rst,
    output logic [DATA_SIZE-1:0]         a1,
    output logic [DATA_SIZE-1:0]         a2,
    output logic [DATA_SIZE-1:0]         a3,
    output logic [DATA_SIZE-1:0]         b1,
    output logic [DATA_SIZE-1:0]         b2,
    output logic [DATA_SIZE-1:0]         b3,
    input  logic [DATA_SIZE-1:0]         c1,
    input  logic [DATA_SIZE-1:0]         c2,
    input  logic [DATA_SIZE-1:0]         c3,
    input  logic [DATA_SIZE-1:0]         c4,
    input  logic [DATA_SIZE-1:0]         c5,
    input  logic [DATA_SIZE-1:0]         c6,
    input  logic [DATA_SIZE-1:0]         c7,
    input  logic [DATA_SIZE-1:0]         c8,
    input  logic [DATA_SIZE-1:0]         c9,
    output logic                         res_valid,
    input  logic                         res_ready,
`ifdef SYSTOLIC_FEEDER_PERF_EN
    output logic [15:0]                  job_count,
    output logic [31:0]                  busy_cycles,
`endif
    output logic [ELEMS*DATA_SIZE-1:0]   res
);

    localparam int CNT_MAX = (DRAIN_CYCLES > FEED_CYCLES) ? DRAIN_CYCLES : FEED_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t                       state_q, state_n;
    logic [CNT_W-1:0]             cnt_q, cnt_n;
    logic                         accept, capture, done;
    logic [ELEMS*DATA_SIZE-1:0]   mat_a_q, mat_b_q, res_q;
    logic                         arr_rst_q, res_valid_q;
    logic [ARR_N*DATA_SIZE-1:0]   rows [ARR_N];
    logic [ARR_N*DATA_SIZE-1:0]   cols [ARR_N];
    logic [DATA_SIZE-1:0]         sel_a [ARR_N];
    logic [DATA_SIZE-1:0]         sel_b [ARR_N];
    logic [DATA_SIZE-1:0]         a_p0 [ARR_N];
    logic [DATA_SIZE-1:0]         b_p0 [ARR_N];

    // Next state / counter; the counter is the feed time t in FEED and the drain count in DRAIN.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        accept  = 1'b0;
        capture = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_n = CLEAR;
                    cnt_n   = '0;
                    accept  = 1'b1;
                end
            end
            CLEAR: begin
                state_n = FEED;
                cnt_n   = '0;
            end
            FEED: begin
                if (cnt_q == CNT_W'(FEED_CYCLES - 1)) begin
                    state_n = DRAIN;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            DRAIN: begin
                if (cnt_q == CNT_W'(DRAIN_CYCLES - 1)) begin
                    state_n = HOLD;
                    cnt_n   = '0;
                    capture = 1'b1;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (res_valid_q && res_ready) begin
                    state_n = IDLE;
                    done    = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Split latched matrices into A rows and B columns for the lane selectors.
    always_comb begin
        for (int i = 0; i < ARR_N; i++) begin
            rows[i] = '0;
            cols[i] = '0;
        end
        for (int r = 0; r < ARR_N; r++) begin
            for (int c = 0; c < ARR_N; c++) begin
                rows[r][c*DATA_SIZE +: DATA_SIZE] = mat_a_q[elem_idx(r, c)*DATA_SIZE +: DATA_SIZE];
                cols[c][r*DATA_SIZE +: DATA_SIZE] = mat_b_q[elem_idx(r, c)*DATA_SIZE +: DATA_SIZE];
            end
        end
    end

    // Selectors look at the upcoming t so the stream registers hold the word for that FEED cycle.
    for (genvar g = 0; g < ARR_N; g++) begin : g_lane
        systolic_skew_sel #(.DATA_SIZE(DATA_SIZE), .CNT_W(CNT_W), .LANE(g)) u_sel_a (
            .vec  (rows[g]),
            .t    (cnt_n),
            .word (sel_a[g])
        );
        systolic_skew_sel #(.DATA_SIZE(DATA_SIZE), .CNT_W(CNT_W), .LANE(g)) u_sel_b (
            .vec  (cols[g]),
            .t    (cnt_n),
            .word (sel_b[g])
        );
    end

    // Control registers: state, counter, array clear pulse and result-valid flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            arr_rst_q   <= 1'b1;
            res_valid_q <= 1'b0;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            arr_rst_q <= (state_n == CLEAR);
            if (capture) begin
                res_valid_q <= 1'b1;
            end else if (done) begin
                res_valid_q <= 1'b0;
            end
        end
    end

    // Stage p0: latched job, registered feed streams and captured result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mat_a_q <= '0;
            mat_b_q <= '0;
            res_q   <= '0;
            for (int i = 0; i < ARR_N; i++) begin
                a_p0[i] <= '0;
                b_p0[i] <= '0;
            end
        end else begin
            if (accept) begin
                mat_a_q <= mat_a;
                mat_b_q <= mat_b;
            end
            if (capture) begin
                res_q <= {c9, c8, c7, c6, c5, c4, c3, c2, c1};
            end
            for (int i = 0; i < ARR_N; i++) begin
                a_p0[i] <= (state_n == FEED) ? sel_a[i] : '0;
                b_p0[i] <= (state_n == FEED) ? sel_b[i] : '0;
            end
        end
    end

`ifdef SYSTOLIC_FEEDER_PERF_EN
    logic [15:0] job_cnt_q;
    logic [31:0] busy_q;

    // Completed-job counter (wrapping) and saturating non-idle cycle counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            job_cnt_q <= '0;
            busy_q    <= '0;
        end else begin
            if (done) begin
                job_cnt_q <= job_cnt_q + 16'd1;
            end
            if (state_q != IDLE && busy_q != 32'hFFFF_FFFF) begin
                busy_q <= busy_q + 32'd1;
            end
        end
    end

    assign job_count   = job_cnt_q;
    assign busy_cycles = busy_q;
`endif

    assign in_ready  = (state_q == IDLE);
    assign arr_rst   = arr_rst_q;
    assign res_valid = res_valid_q;
    assign res       = res_q;
    assign a1        = a_p0[0];
    assign a2        = a_p0[1];
    assign a3        = a_p0[2];
    assign b1        = b_p0[0];
    assign b2        = b_p0[1];
    assign b3        = b_p0[2];

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: a cycle model of the 3x3 systolic array supplies
// c1..c9; a job-timeline model derives expected outputs from matrix products.
// Honours SYSTOLIC_FEEDER_PERF_EN for the optional counters.
module tb_systolic_feeder;

    localparam int DW    = 32;
    localparam int DR    = 5;
    localparam int HOLDP = 6 + DR;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         res_ready = 1'b0;
    logic [287:0] mat_a = '0, mat_b = '0;
    logic         in_ready, arr_rst, res_valid;
    logic [31:0]  a1, a2, a3, b1, b2, b3;
    logic [31:0]  c1, c2, c3, c4, c5, c6, c7, c8, c9;
    logic [287:0] res;
`ifdef SYSTOLIC_FEEDER_PERF_EN
    logic [15:0]  job_count;
    logic [31:0]  busy_cycles;
`endif

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    systolic_feeder #(.DATA_SIZE(DW), .DRAIN_CYCLES(DR)) dut (
        .clk(clk), .rst(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .mat_a(mat_a), .mat_b(mat_b), .arr_rst(arr_rst),
        .a1(a1), .a2(a2), .a3(a3), .b1(b1), .b2(b2), .b3(b3),
        .c1(c1), .c2(c2), .c3(c3), .c4(c4), .c5(c5), .c6(c6), .c7(c7), .c8(c8), .c9(c9),
        .res_valid(res_valid), .res_ready(res_ready),
`ifdef SYSTOLIC_FEEDER_PERF_EN
        .job_count(job_count), .busy_cycles(busy_cycles),
`endif
        .res(res)
    );

    function automatic logic [31:0] el(input logic [287:0] m, input int r, input int c);
        return m[(3*r+c)*32 +: 32];
    endfunction

    function automatic logic [287:0] mk_lin(input int base, input int step);
        logic [287:0] m;
        for (int e = 0; e < 9; e++) m[e*32 +: 32] = 32'(base + step*e);
        return m;
    endfunction

    function automatic logic [287:0] mk_const(input int v);
        return mk_lin(v, 0);
    endfunction

    function automatic logic [287:0] mk_id();
        logic [287:0] m;
        m = '0;
        for (int i = 0; i < 3; i++) m[(4*i)*32 +: 32] = 32'd1;
        return m;
    endfunction

    function automatic logic [287:0] matmul(input logic [287:0] a, input logic [287:0] b);
        logic [287:0] r;
        logic [31:0]  s;
        r = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                s = '0;
                for (int k = 0; k < 3; k++) s = s + el(a, i, k) * el(b, k, j);
                r[(3*i+j)*32 +: 32] = s;
            end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [287:0] act, input logic [287:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Output-stationary 3x3 array: a flows right, b flows down, each PE accumulates.
    logic [31:0] apipe [3][3];
    logic [31:0] bpipe [3][3];
    logic [31:0] acc   [3][3];
    logic [31:0] a_s [3];
    logic [31:0] b_s [3];
    assign a_s[0] = a1; assign a_s[1] = a2; assign a_s[2] = a3;
    assign b_s[0] = b1; assign b_s[1] = b2; assign b_s[2] = b3;
    assign c1 = acc[0][0]; assign c2 = acc[0][1]; assign c3 = acc[0][2];
    assign c4 = acc[1][0]; assign c5 = acc[1][1]; assign c6 = acc[1][2];
    assign c7 = acc[2][0]; assign c8 = acc[2][1]; assign c9 = acc[2][2];

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                if (arr_rst) begin
                    apipe[i][j] <= '0;
                    bpipe[i][j] <= '0;
                    acc[i][j]   <= '0;
                end else begin
                    apipe[i][j] <= (j == 0) ? a_s[i] : apipe[i][j-1];
                    bpipe[i][j] <= (i == 0) ? b_s[j] : bpipe[i-1][j];
                    acc[i][j]   <= acc[i][j] + ((j == 0) ? a_s[i] : apipe[i][j-1])
                                             * ((i == 0) ? b_s[j] : bpipe[i-1][j]);
                end
            end
    end

    // Job timeline model: p = cycles since accept (0 clear, 1..5 feed, then drain, then hold).
    bit           busy_m, rstflag_m;
    int           p_m;
    logic [287:0] ma_m, mb_m, res_m;
    int unsigned  jobs_m, busy_cyc_m;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_m <= 1'b0; p_m <= 0; rstflag_m <= 1'b1;
            ma_m <= '0; mb_m <= '0; res_m <= '0;
            jobs_m <= 0; busy_cyc_m <= 0;
        end else begin
            rstflag_m <= 1'b0;
            if (busy_m && busy_cyc_m != 32'hFFFF_FFFF) busy_cyc_m <= busy_cyc_m + 1;
            if (!busy_m) begin
                if (in_valid) begin
                    busy_m <= 1'b1; p_m <= 0; ma_m <= mat_a; mb_m <= mat_b;
                end
            end else if (p_m == HOLDP) begin
                if (res_ready) begin
                    busy_m <= 1'b0; jobs_m <= jobs_m + 1;
                end
            end else begin
                p_m <= p_m + 1;
                if (p_m + 1 == HOLDP) res_m <= matmul(ma_m, mb_m);
            end
        end
    end

    // Compare all outputs against the model every cycle.
    always @(negedge clk) begin : cmp
        logic [191:0] se;
        int t;
        if (cmp_en) begin
            se = '0;
            if (busy_m && p_m >= 1 && p_m <= 5) begin
                t = p_m - 1;
                for (int i = 0; i < 3; i++)
                    if (t - i >= 0 && t - i <= 2) begin
                        se[(5-i)*32 +: 32] = el(ma_m, i, t - i);
                        se[(2-i)*32 +: 32] = el(mb_m, t - i, i);
                    end
            end
            chk("streams", {a1, a2, a3, b1, b2, b3}, se);
            chk("in_ready", in_ready, !busy_m);
            chk("arr_rst", arr_rst, rstflag_m || (busy_m && p_m == 0));
            chk("res_valid", res_valid, busy_m && p_m == HOLDP);
            chk("res", res, res_m);
`ifdef SYSTOLIC_FEEDER_PERF_EN
            chk("job_count", job_count, jobs_m[15:0]);
            chk("busy_cycles", busy_cycles, busy_cyc_m);
`endif
        end
    end

    logic [191:0] rec_s [12];
    logic         rec_r [12];
    logic [287:0] last_res;
    int           last_lat;

    task automatic wait_idle();
        int n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait", in_ready, 1'b1);
    endtask

    task automatic run_job(input logic [287:0] A, input logic [287:0] B,
                           input int hold_lo, input bit pulse_iv);
        int lat;
        wait_idle();
        mat_a = A; mat_b = B; in_valid = 1'b1;
        res_ready = (hold_lo == 0);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        rec_s[0] = {a1, a2, a3, b1, b2, b3};
        rec_r[0] = arr_rst;
        while (res_valid !== 1'b1 && lat < 40) begin
            if (pulse_iv && (lat == 3 || lat == 8)) begin
                in_valid = 1'b1; mat_a = {9{$urandom}}; mat_b = {9{$urandom}};
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            lat++;
            if (lat < 12) begin
                rec_s[lat] = {a1, a2, a3, b1, b2, b3};
                rec_r[lat] = arr_rst;
            end
        end
        in_valid = 1'b0;
        last_lat = lat;
        last_res = res;
        for (int h = 0; h < hold_lo; h++) begin
            @(negedge clk);
            chk("hold_res_stable", res, last_res);
            chk("hold_in_ready", in_ready, 1'b0);
            chk("hold_valid", res_valid, 1'b1);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("res_valid_drop", res_valid, 1'b0);
        chk("in_ready_back", in_ready, 1'b1);
    endtask

    int ta1[5] = '{1, 2, 3, 0, 0};
    int ta2[5] = '{0, 4, 5, 6, 0};
    int ta3[5] = '{0, 0, 7, 8, 9};
    int tb1[5] = '{1, 4, 7, 0, 0};
    int tb2[5] = '{0, 2, 5, 8, 0};
    int tb3[5] = '{0, 0, 3, 6, 9};
    int exp1[9] = '{30, 36, 42, 66, 81, 96, 102, 126, 150};

    initial begin
        logic [287:0] lit;
        logic [191:0] sv;

        // Reset and reset-state checks
        #1 rst_n = 1'b0;
        #1 cmp_en = 1'b1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_arr_rst", arr_rst, 1'b1);
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_res", res, '0);
        chk("rst_streams", {a1, a2, a3, b1, b2, b3}, '0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Job 1: fixed feed sequence, latency and product
        run_job(mk_lin(1, 1), mk_lin(1, 1), 0, 1'b0);
        for (int t = 0; t < 5; t++) begin
            sv = {32'(ta1[t]), 32'(ta2[t]), 32'(ta3[t]), 32'(tb1[t]), 32'(tb2[t]), 32'(tb3[t])};
            chk($sformatf("feed_t%0d", t), rec_s[t+1], sv);
        end
        chk("latency", 32'(last_lat), 32'd11);
        for (int e = 0; e < 9; e++) lit[e*32 +: 32] = 32'(exp1[e]);
        chk("res_job1", last_res, lit);

        // Job 2: identity x B returns B; single clear pulse before feed
        chk("arr_rst_idle", arr_rst, 1'b0);
        run_job(mk_id(), mk_lin(9, -1), 0, 1'b0);
        chk("res_ident", last_res, mk_lin(9, -1));
        chk("clear_pulse", rec_r[0], 1'b1);
        for (int l = 1; l <= 5; l++) chk("clear_low_feed", rec_r[l], 1'b0);

        // Back-to-back with a stalled consumer, second job must not see residue
        run_job(mk_lin(1, 1), mk_lin(1, 1), 4, 1'b0);
        run_job(mk_const(2), mk_const(1), 0, 1'b0);
        chk("res_sixes", last_res, mk_const(6));

        // in_valid during FEED and DRAIN is ignored
        run_job(mk_lin(3, 2), mk_lin(1, 3), 1, 1'b1);
        chk("res_ignore_iv", last_res, matmul(mk_lin(3, 2), mk_lin(1, 3)));

        // Reset in the middle of FEED
        wait_idle();
        mat_a = mk_lin(1, 1); mat_b = mk_id(); in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("feed_t2_a1", a1, 32'd3);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_streams", {a1, a2, a3, b1, b2, b3}, '0);
        chk("abort_in_ready", in_ready, 1'b1);
        chk("abort_res_valid", res_valid, 1'b0);
        chk("abort_arr_rst", arr_rst, 1'b1);
        chk("abort_res", res, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_abort_ready", in_ready, 1'b1);
        run_job(mk_lin(1, 1), mk_id(), 0, 1'b0);
        chk("res_after_abort", last_res, mk_lin(1, 1));

        // Random traffic with occasional resets
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 3) == 0);
            res_ready = ($urandom_range(0, 2) == 0);
            for (int e = 0; e < 9; e++) begin
                mat_a[e*32 +: 32] = n[0] ? $urandom : 32'($urandom_range(0, 15));
                mat_b[e*32 +: 32] = n[0] ? $urandom : 32'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 399) == 0) begin
                #1 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        in_valid = 1'b0; res_ready = 1'b1;
        repeat (20) @(negedge clk);
        res_ready = 1'b0;

        // Fresh reset, then three jobs for the counters
        #1 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int j = 0; j < 3; j++) begin
            run_job(mk_lin(j, 1), mk_lin(2, j), 0, 1'b0);
            chk("res_perf_job", last_res, matmul(mk_lin(j, 1), mk_lin(2, j)));
        end
`ifdef SYSTOLIC_FEEDER_PERF_EN
        chk("job_count3", job_count, 16'd3);
        chk("busy_cycles36", busy_cycles, 32'd36);
`endif

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
